// File: rtl/kernel_send_sched_pkg.sv
// Shared types and helpers for the send-path descriptor scheduler.
package kernel_send_sched_pkg;

    // Scheduler state encoding; also reported in the status word.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        ISSUE = 2'd2,
        WAIT  = 2'd3
    } state_t;

    // Status word layout.
    localparam int STAT_COUNT_LSB = 0;
    localparam int STAT_COUNT_W   = 8;
    localparam int STAT_STATE_LSB = 8;
    localparam int STAT_STATE_W   = 3;
    localparam int STAT_IRQ_BIT   = 11;
    localparam int STAT_ERR_LSB   = 12;
    localparam int STAT_ERR_W     = 4;
    localparam int STAT_DONE_LSB  = 16;
    localparam int STAT_DONE_W    = 16;

    // Width used for chunk arithmetic; callers zero-extend into it and
    // truncate the result back to their own pointer width.
    localparam int CALC_W = 64;

    // Largest chunk that starts at ptr without crossing a max_chunk-aligned
    // boundary, limited by the bytes remaining. max_chunk is a power of two.
    function automatic logic [CALC_W-1:0] chunk_size(
        input logic [CALC_W-1:0] ptr,
        input logic [CALC_W-1:0] rem,
        input logic [CALC_W-1:0] max_chunk
    );
        logic [CALC_W-1:0] room;
        room = max_chunk - (ptr & (max_chunk - CALC_W'(1)));
        return (rem < room) ? rem : room;
    endfunction

endpackage

// File: rtl/kernel_send_sched_if.sv
// Host request and engine chunk signals of the send scheduler.
//
// Request side: a request transfers on a rising edge where req_valid and
// req_ready are both high; req_ptr/req_len must be stable while req_valid is
// high. Engine side: eng_start is a one-cycle pulse, eng_ptr/eng_len hold from
// eng_start until the matching one-cycle eng_done pulse.
interface kernel_send_sched_if #(
    parameter int LEN_WIDTH = 32
);
    logic                 req_valid;
    logic                 req_ready;
    logic [LEN_WIDTH-1:0] req_ptr;
    logic [LEN_WIDTH-1:0] req_len;
    logic                 eng_start;
    logic [LEN_WIDTH-1:0] eng_ptr;
    logic [LEN_WIDTH-1:0] eng_len;
    logic                 eng_done;

    // Host/engine side.
    modport master (
        output req_valid, req_ptr, req_len, eng_done,
        input  req_ready, eng_start, eng_ptr, eng_len
    );

    // Scheduler side.
    modport slave (
        input  req_valid, req_ptr, req_len, eng_done,
        output req_ready, eng_start, eng_ptr, eng_len
    );
endinterface

// File: rtl/kernel_desc_fifo.sv
// Synchronous descriptor FIFO with a one-cycle flush.
module kernel_desc_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             aclk,
    input  logic             aresetn,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    input  logic             flush,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = mem[rd_ptr];

    // Storage write; a flush in the same cycle discards the entry anyway.
    always_ff @(posedge aclk) begin
        if (do_push && !flush) mem[wr_ptr] <= din;
    end

    // Pointers and occupancy; flush wins over push and pop.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end
endmodule

// File: rtl/kernel_send_sched.sv
// Send-path scheduler: queues host requests, splits them into boundary-safe
// chunks and hands them one at a time to the send DMA engine.
module kernel_send_sched
    import kernel_send_sched_pkg::*;
#(
    parameter int QDEPTH    = 4,
    parameter int MAX_CHUNK = 4096,
    parameter int LEN_WIDTH = 32
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    kernel_send_sched_if.slave      bus,
    input  logic                    flush,
    input  logic                    irq_ack,
    output logic                    done_irq,
    output logic [31:0]             stat
);
    localparam int CNT_W = $clog2(QDEPTH) + 1;

    state_t                 state;
    logic [LEN_WIDTH-1:0]   cur_ptr;
    logic [LEN_WIDTH-1:0]   rem;
    logic [LEN_WIDTH-1:0]   chunk;
    logic [LEN_WIDTH-1:0]   eng_ptr_q;
    logic [LEN_WIDTH-1:0]   eng_len_q;
    logic                   eng_start_q;
    logic                   flush_pend;
    logic                   pend_eff;
    logic [3:0]             err_cnt;
    logic [15:0]            done_cnt;

    logic                   fifo_full;
    logic                   fifo_empty;
    logic [CNT_W-1:0]       fifo_count;
    logic [2*LEN_WIDTH-1:0] fifo_dout;
    logic                   accept;
    logic                   fifo_push;
    logic                   fifo_pop;
    logic                   zero_req;
    logic                   desc_done;

    assign bus.req_ready = ~fifo_full;
    assign bus.eng_start = eng_start_q;
    assign bus.eng_ptr   = eng_ptr_q;
    assign bus.eng_len   = eng_len_q;

    assign accept    = bus.req_valid & ~fifo_full;
    assign fifo_push = accept & (bus.req_len != '0);
    assign zero_req  = accept & (bus.req_len == '0);
    // No pop while a flush is clearing the queue.
    assign fifo_pop  = (state == IDLE) & ~fifo_empty & ~flush;
    // A flush arriving together with eng_done counts as already pending.
    assign pend_eff  = flush_pend | flush;
    assign desc_done = (state == WAIT) & bus.eng_done & (rem == '0) & ~pend_eff;

    assign chunk = LEN_WIDTH'(chunk_size(CALC_W'(cur_ptr), CALC_W'(rem),
                                         CALC_W'(MAX_CHUNK)));

    kernel_desc_fifo #(
        .WIDTH (2*LEN_WIDTH),
        .DEPTH (QDEPTH)
    ) u_fifo (
        .aclk    (aclk),
        .aresetn (aresetn),
        .push    (fifo_push),
        .din     ({bus.req_ptr, bus.req_len}),
        .pop     (fifo_pop),
        .dout    (fifo_dout),
        .flush   (flush),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    // Descriptor state machine: pop, size a chunk, pulse start, await done.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state       <= IDLE;
            cur_ptr     <= '0;
            rem         <= '0;
            eng_ptr_q   <= '0;
            eng_len_q   <= '0;
            eng_start_q <= 1'b0;
            flush_pend  <= 1'b0;
        end else begin
            eng_start_q <= 1'b0;
            case (state)
                IDLE: begin
                    flush_pend <= 1'b0;
                    if (fifo_pop) begin
                        cur_ptr <= fifo_dout[2*LEN_WIDTH-1:LEN_WIDTH];
                        rem     <= fifo_dout[LEN_WIDTH-1:0];
                        state   <= CALC;
                    end
                end
                CALC: begin
                    if (flush) flush_pend <= 1'b1;
                    eng_ptr_q   <= cur_ptr;
                    eng_len_q   <= chunk;
                    eng_start_q <= 1'b1;
                    state       <= ISSUE;
                end
                ISSUE: begin
                    if (flush) flush_pend <= 1'b1;
                    cur_ptr <= cur_ptr + eng_len_q;
                    rem     <= rem - eng_len_q;
                    state   <= WAIT;
                end
                WAIT: begin
                    if (flush) flush_pend <= 1'b1;
                    if (bus.eng_done) begin
                        if (rem != '0 && !pend_eff) begin
                            state <= CALC;
                        end else begin
                            state      <= IDLE;
                            flush_pend <= 1'b0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Completion interrupt and counters; a completion beats a same-cycle ack.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            done_irq <= 1'b0;
            done_cnt <= '0;
            err_cnt  <= '0;
        end else begin
            if (zero_req && err_cnt != 4'hF) err_cnt <= err_cnt + 4'd1;
            if (desc_done) begin
                done_irq <= 1'b1;
                done_cnt <= done_cnt + 16'd1;
            end else if (irq_ack) begin
                done_irq <= 1'b0;
            end
        end
    end

    // Status word assembly.
    always_comb begin
        stat = '0;
        stat[STAT_COUNT_LSB +: STAT_COUNT_W] = STAT_COUNT_W'(fifo_count);
        stat[STAT_STATE_LSB +: STAT_STATE_W] = STAT_STATE_W'(state);
        stat[STAT_IRQ_BIT]                   = done_irq;
        stat[STAT_ERR_LSB +: STAT_ERR_W]     = err_cnt;
        stat[STAT_DONE_LSB +: STAT_DONE_W]   = done_cnt;
    end
endmodule

// File: tb/tb_kernel_send_sched.sv
// Directed bench for kernel_send_sched: latency, chunking, queueing,
// zero-length errors, flush, interrupt acknowledge and async reset.
module tb_kernel_send_sched;
    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic        flush = 1'b0;
    logic        irq_ack = 1'b0;
    logic        done_irq;
    logic [31:0] stat;
    int          checks = 0;
    int          errors = 0;
    logic [15:0] exp_done = 16'd0;

    kernel_send_sched_if #(.LEN_WIDTH(32)) bus();

    kernel_send_sched #(
        .QDEPTH    (4),
        .MAX_CHUNK (4096),
        .LEN_WIDTH (32)
    ) dut (
        .aclk     (aclk),
        .aresetn  (aresetn),
        .bus      (bus),
        .flush    (flush),
        .irq_ack  (irq_ack),
        .done_irq (done_irq),
        .stat     (stat)
    );

    // Clock and watchdog.
    always #5 aclk = ~aclk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One clock: sample point is 1 ns after the edge; pulse inputs drop.
    task automatic step();
        @(posedge aclk);
        #1;
        bus.req_valid = 1'b0;
        bus.eng_done  = 1'b0;
        flush         = 1'b0;
        irq_ack       = 1'b0;
    endtask

    task automatic push_req(input logic [31:0] ptr, input logic [31:0] len);
        bus.req_valid = 1'b1;
        bus.req_ptr   = ptr;
        bus.req_len   = len;
    endtask

    // Clocks until eng_start is seen (counting the first step), -1 on timeout.
    task automatic wait_start(output int n);
        bit hit;
        hit = 1'b0;
        n = 0;
        while (!hit && n < 20) begin
            step();
            n++;
            hit = bus.eng_start;
        end
        if (!hit) n = -1;
    endtask

    task automatic test_reset();
        #23;
        checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", bus.req_ready); end
        checks++; if (bus.eng_start !== 1'b0) begin errors++; $display("FAIL reset_start: got %b expected 0", bus.eng_start); end
        checks++; if (bus.eng_ptr !== 32'h0) begin errors++; $display("FAIL reset_ptr: got %h expected 0", bus.eng_ptr); end
        checks++; if (bus.eng_len !== 32'h0) begin errors++; $display("FAIL reset_len: got %h expected 0", bus.eng_len); end
        checks++; if (done_irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b expected 0", done_irq); end
        checks++; if (stat !== 32'h0) begin errors++; $display("FAIL reset_stat: got %h expected 0", stat); end
        step();
        aresetn = 1'b1;
        step();
    endtask

    task automatic test_single();
        int n;
        push_req(32'h1000, 32'h800);
        wait_start(n);
        checks++; if (n !== 3) begin errors++; $display("FAIL single_latency: got %0d expected 3", n); end
        checks++; if (bus.eng_ptr !== 32'h1000) begin errors++; $display("FAIL single_ptr: got %h expected 1000", bus.eng_ptr); end
        checks++; if (bus.eng_len !== 32'h800) begin errors++; $display("FAIL single_len: got %h expected 800", bus.eng_len); end
        // eng_done during ISSUE must be ignored.
        bus.eng_done = 1'b1;
        step();
        checks++; if (stat[10:8] !== 3'd3) begin errors++; $display("FAIL stray_done_state: got %0d expected 3", stat[10:8]); end
        checks++; if (done_irq !== 1'b0) begin errors++; $display("FAIL stray_done_irq: got %b expected 0", done_irq); end
        bus.eng_done = 1'b1;
        step();
        exp_done++;
        checks++; if (done_irq !== 1'b1) begin errors++; $display("FAIL single_irq: got %b expected 1", done_irq); end
        checks++; if (stat[31:16] !== exp_done) begin errors++; $display("FAIL single_done_cnt: got %0d expected %0d", stat[31:16], exp_done); end
        checks++; if (stat[10:8] !== 3'd0) begin errors++; $display("FAIL single_idle: got %0d expected 0", stat[10:8]); end
        irq_ack = 1'b1;
        step();
        checks++; if (done_irq !== 1'b0) begin errors++; $display("FAIL single_ack: got %b expected 0", done_irq); end
    endtask

    task automatic test_split();
        int n;
        logic [31:0] ep [3];
        logic [31:0] el [3];
        ep[0] = 32'h1F00; el[0] = 32'h100;
        ep[1] = 32'h2000; el[1] = 32'h1000;
        ep[2] = 32'h3000; el[2] = 32'h200;
        push_req(32'h1F00, 32'h1300);
        wait_start(n);
        for (int i = 0; i < 3; i++) begin
            checks++; if (n !== ((i == 0) ? 3 : 2)) begin errors++; $display("FAIL split_latency%0d: got %0d expected %0d", i, n, (i == 0) ? 3 : 2); end
            checks++; if (bus.eng_ptr !== ep[i]) begin errors++; $display("FAIL split_ptr%0d: got %h expected %h", i, bus.eng_ptr, ep[i]); end
            checks++; if (bus.eng_len !== el[i]) begin errors++; $display("FAIL split_len%0d: got %h expected %h", i, bus.eng_len, el[i]); end
            step();
            checks++; if (done_irq !== 1'b0) begin errors++; $display("FAIL split_irq_early%0d: got %b expected 0", i, done_irq); end
            bus.eng_done = 1'b1;
            if (i < 2) wait_start(n);
            else step();
        end
        exp_done++;
        checks++; if (done_irq !== 1'b1) begin errors++; $display("FAIL split_irq: got %b expected 1", done_irq); end
        checks++; if (stat[31:16] !== exp_done) begin errors++; $display("FAIL split_done_cnt: got %0d expected %0d", stat[31:16], exp_done); end
        irq_ack = 1'b1;
        step();
    endtask

    task automatic test_back_to_back_full();
        int n;
        for (int i = 0; i < 5; i++) begin
            checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL full_ready%0d: got %b expected 1", i, bus.req_ready); end
            push_req(32'h0001_0000 + 32'(i) * 32'h1000, 32'(i + 1) * 32'h10);
            step();
        end
        checks++; if (bus.req_ready !== 1'b0) begin errors++; $display("FAIL full_not_ready: got %b expected 0", bus.req_ready); end
        checks++; if (stat[7:0] !== 8'd4) begin errors++; $display("FAIL full_count: got %0d expected 4", stat[7:0]); end
        checks++; if (stat[10:8] !== 3'd3) begin errors++; $display("FAIL full_state: got %0d expected 3", stat[10:8]); end
        checks++; if (bus.eng_ptr !== 32'h0001_0000) begin errors++; $display("FAIL full_ptr0: got %h expected 10000", bus.eng_ptr); end
        checks++; if (bus.eng_len !== 32'h10) begin errors++; $display("FAIL full_len0: got %h expected 10", bus.eng_len); end
        for (int i = 0; i < 5; i++) begin
            bus.eng_done = 1'b1;
            exp_done++;
            if (i < 4) begin
                wait_start(n);
                checks++; if (n !== 3) begin errors++; $display("FAIL full_latency%0d: got %0d expected 3", i + 1, n); end
                checks++; if (bus.eng_ptr !== 32'h0001_0000 + 32'(i + 1) * 32'h1000) begin errors++; $display("FAIL full_ptr%0d: got %h expected %h", i + 1, bus.eng_ptr, 32'h0001_0000 + 32'(i + 1) * 32'h1000); end
                checks++; if (bus.eng_len !== 32'(i + 2) * 32'h10) begin errors++; $display("FAIL full_len%0d: got %h expected %h", i + 1, bus.eng_len, 32'(i + 2) * 32'h10); end
                if (i == 0) begin
                    checks++; if (stat[7:0] !== 8'd3) begin errors++; $display("FAIL full_count_after_pop: got %0d expected 3", stat[7:0]); end
                    checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL full_ready_after_pop: got %b expected 1", bus.req_ready); end
                end
                step();
            end else begin
                step();
            end
        end
        checks++; if (stat[31:16] !== exp_done) begin errors++; $display("FAIL full_done_cnt: got %0d expected %0d", stat[31:16], exp_done); end
        irq_ack = 1'b1;
        step();
    endtask

    task automatic test_zero_len();
        int starts;
        for (int i = 0; i < 3; i++) begin
            push_req(32'h100, 32'h0);
            step();
        end
        starts = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (bus.eng_start === 1'b1) starts++;
        end
        checks++; if (starts !== 0) begin errors++; $display("FAIL zero_no_start: got %0d expected 0", starts); end
        checks++; if (stat[15:12] !== 4'd3) begin errors++; $display("FAIL zero_err3: got %0d expected 3", stat[15:12]); end
        checks++; if (stat[7:0] !== 8'd0) begin errors++; $display("FAIL zero_count: got %0d expected 0", stat[7:0]); end
        for (int i = 0; i < 20; i++) begin
            push_req(32'h200, 32'h0);
            step();
        end
        checks++; if (stat[15:12] !== 4'd15) begin errors++; $display("FAIL zero_err_sat: got %0d expected 15", stat[15:12]); end
    endtask

    task automatic test_flush();
        int n;
        int starts;
        push_req(32'h5000, 32'h2800);
        wait_start(n);
        checks++; if (n !== 3) begin errors++; $display("FAIL flush_latency: got %0d expected 3", n); end
        checks++; if (bus.eng_len !== 32'h1000) begin errors++; $display("FAIL flush_len: got %h expected 1000", bus.eng_len); end
        push_req(32'h8000, 32'h10);
        step();
        push_req(32'h9000, 32'h10);
        step();
        checks++; if (stat[7:0] !== 8'd2) begin errors++; $display("FAIL flush_queued: got %0d expected 2", stat[7:0]); end
        flush = 1'b1;
        step();
        checks++; if (stat[7:0] !== 8'd0) begin errors++; $display("FAIL flush_count: got %0d expected 0", stat[7:0]); end
        checks++; if (stat[10:8] !== 3'd3) begin errors++; $display("FAIL flush_still_wait: got %0d expected 3", stat[10:8]); end
        bus.eng_done = 1'b1;
        step();
        checks++; if (stat[10:8] !== 3'd0) begin errors++; $display("FAIL flush_to_idle: got %0d expected 0", stat[10:8]); end
        starts = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (bus.eng_start === 1'b1) starts++;
        end
        checks++; if (starts !== 0) begin errors++; $display("FAIL flush_no_start: got %0d expected 0", starts); end
        checks++; if (done_irq !== 1'b0) begin errors++; $display("FAIL flush_irq: got %b expected 0", done_irq); end
        checks++; if (stat[31:16] !== exp_done) begin errors++; $display("FAIL flush_done_cnt: got %0d expected %0d", stat[31:16], exp_done); end
    endtask

    task automatic test_ack_collision();
        int n;
        push_req(32'h7000, 32'h40);
        wait_start(n);
        step();
        bus.eng_done = 1'b1;
        irq_ack      = 1'b1;
        step();
        exp_done++;
        checks++; if (done_irq !== 1'b1) begin errors++; $display("FAIL ack_collision_irq: got %b expected 1", done_irq); end
        checks++; if (stat[31:16] !== exp_done) begin errors++; $display("FAIL ack_collision_cnt: got %0d expected %0d", stat[31:16], exp_done); end
        step();
        checks++; if (done_irq !== 1'b1) begin errors++; $display("FAIL ack_irq_held: got %b expected 1", done_irq); end
        irq_ack = 1'b1;
        step();
        checks++; if (done_irq !== 1'b0) begin errors++; $display("FAIL ack_clear: got %b expected 0", done_irq); end
    endtask

    task automatic test_async_reset();
        int n;
        int starts;
        push_req(32'hA000, 32'h40);
        wait_start(n);
        step();
        bus.eng_done = 1'b1;
        step();
        push_req(32'hB000, 32'h2000);
        wait_start(n);
        step();
        checks++; if (stat[10:8] !== 3'd3) begin errors++; $display("FAIL rst_pre_state: got %0d expected 3", stat[10:8]); end
        checks++; if (done_irq !== 1'b1) begin errors++; $display("FAIL rst_pre_irq: got %b expected 1", done_irq); end
        #2;
        aresetn = 1'b0;
        #1;
        checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b expected 1", bus.req_ready); end
        checks++; if (bus.eng_ptr !== 32'h0) begin errors++; $display("FAIL rst_ptr: got %h expected 0", bus.eng_ptr); end
        checks++; if (bus.eng_len !== 32'h0) begin errors++; $display("FAIL rst_len: got %h expected 0", bus.eng_len); end
        checks++; if (done_irq !== 1'b0) begin errors++; $display("FAIL rst_irq: got %b expected 0", done_irq); end
        checks++; if (stat !== 32'h0) begin errors++; $display("FAIL rst_stat: got %h expected 0", stat); end
        step();
        aresetn = 1'b1;
        bus.eng_done = 1'b1;
        step();
        starts = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (bus.eng_start === 1'b1) starts++;
        end
        checks++; if (starts !== 0) begin errors++; $display("FAIL rst_late_done_start: got %0d expected 0", starts); end
        checks++; if (stat !== 32'h0) begin errors++; $display("FAIL rst_late_done_stat: got %h expected 0", stat); end
    endtask

    initial begin
        bus.req_valid = 1'b0;
        bus.req_ptr   = '0;
        bus.req_len   = '0;
        bus.eng_done  = 1'b0;
        test_reset();
        test_single();
        test_split();
        test_back_to_back_full();
        test_zero_len();
        test_flush();
        test_ack_collision();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
